// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction codes, DR select.
package jtag_pkg;

    localparam int unsigned IR_WIDTH = 4;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] INSTR_IDCODE  = 4'b0001;
    localparam logic [IR_WIDTH-1:0] INSTR_USERREG = 4'b0010;
    localparam logic [IR_WIDTH-1:0] INSTR_BYPASS  = 4'b1111;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE    = 4'b0001;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

endpackage

// File: rtl/jtag_edge_sync.sv
// Synchronises the raw JTAG pins into clk and turns synced TCK transitions
// into single-cycle rise/fall pulses.
module jtag_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_sync,
    output logic tdi_sync
);

    logic [SYNC_STAGES-1:0] tck_chain;
    logic [SYNC_STAGES-1:0] tms_chain;
    logic [SYNC_STAGES-1:0] tdi_chain;
    logic                   tck_prev;

    // Equal-depth chains keep TMS/TDI aligned with the synced TCK edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_chain <= '0;
            tms_chain <= '0;
            tdi_chain <= '0;
            tck_prev  <= 1'b0;
        end else begin
            tck_chain <= {tck_chain[SYNC_STAGES-2:0], tck};
            tms_chain <= {tms_chain[SYNC_STAGES-2:0], tms};
            tdi_chain <= {tdi_chain[SYNC_STAGES-2:0], tdi};
            tck_prev  <= tck_chain[SYNC_STAGES-1];
        end
    end

    assign tck_rise = tck_chain[SYNC_STAGES-1] & ~tck_prev;
    assign tck_fall = ~tck_chain[SYNC_STAGES-1] & tck_prev;
    assign tms_sync = tms_chain[SYNC_STAGES-1];
    assign tdi_sync = tdi_chain[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_oversampled.sv
// Oversampled IEEE 1149.1 TAP with IR, IDCODE and BYPASS registers.
// Define JTAG_TAP_USERREG_EN to add the 8-bit USERREG data register.
module jtag_tap_oversampled
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE      = 32'h3BA0_0477,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_oe,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir,
    output logic [7:0]          user_reg
);

    logic tck_rise, tck_fall, tms_sync, tdi_sync;

    jtag_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_sync (tms_sync),
        .tdi_sync (tdi_sync)
    );

    tap_state_t          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_sr;
    logic [31:0]         id_sr;
    logic                bypass_sr;
    logic                dr_lsb;
    logic                tdo_q, tdo_oe_q;
    dr_sel_t             dr_sel;

    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_q)
            INSTR_IDCODE:  dr_sel = DR_IDCODE;
`ifdef JTAG_TAP_USERREG_EN
            INSTR_USERREG: dr_sel = DR_USER;
`endif
            default:       dr_sel = DR_BYPASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= TEST_LOGIC_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TEST_LOGIC_RESET: state_d = tms_sync ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state_d = tms_sync ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_DR:        state_d = tms_sync ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       state_d = tms_sync ? EXIT1_DR  : SHIFT_DR;
                SHIFT_DR:         state_d = tms_sync ? EXIT1_DR  : SHIFT_DR;
                EXIT1_DR:         state_d = tms_sync ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         state_d = tms_sync ? EXIT2_DR  : PAUSE_DR;
                EXIT2_DR:         state_d = tms_sync ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        state_d = tms_sync ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_IR:        state_d = tms_sync ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_d = tms_sync ? EXIT1_IR  : SHIFT_IR;
                SHIFT_IR:         state_d = tms_sync ? EXIT1_IR  : SHIFT_IR;
                EXIT1_IR:         state_d = tms_sync ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         state_d = tms_sync ? EXIT2_IR  : PAUSE_IR;
                EXIT2_IR:         state_d = tms_sync ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        state_d = tms_sync ? SELECT_DR : RUN_TEST_IDLE;
                default:          state_d = TEST_LOGIC_RESET;
            endcase
        end
    end

    // Capture/shift/update act on the rising edge that leaves the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q      <= INSTR_IDCODE;
            ir_sr     <= '0;
            id_sr     <= '0;
            bypass_sr <= 1'b0;
        end else if (tck_rise) begin
            case (state_q)
                TEST_LOGIC_RESET: ir_q  <= INSTR_IDCODE;
                CAPTURE_IR:       ir_sr <= IR_CAPTURE;
                SHIFT_IR:         ir_sr <= {tdi_sync, ir_sr[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_q  <= ir_sr;
                CAPTURE_DR: begin
                    if (dr_sel == DR_IDCODE)      id_sr     <= IDCODE;
                    else if (dr_sel == DR_BYPASS) bypass_sr <= 1'b0;
                end
                SHIFT_DR: begin
                    if (dr_sel == DR_IDCODE)      id_sr     <= {tdi_sync, id_sr[31:1]};
                    else if (dr_sel == DR_BYPASS) bypass_sr <= tdi_sync;
                end
                default: ;
            endcase
        end
    end

`ifdef JTAG_TAP_USERREG_EN
    logic [7:0] user_sr, user_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            user_sr <= '0;
            user_q  <= '0;
        end else if (tck_rise && dr_sel == DR_USER) begin
            case (state_q)
                CAPTURE_DR: user_sr <= user_q;
                SHIFT_DR:   user_sr <= {tdi_sync, user_sr[7:1]};
                UPDATE_DR:  user_q  <= user_sr;
                default: ;
            endcase
        end
    end

    assign user_reg = user_q;
`else
    assign user_reg = '0;
`endif

    always_comb begin
        dr_lsb = bypass_sr;
        case (dr_sel)
            DR_IDCODE: dr_lsb = id_sr[0];
`ifdef JTAG_TAP_USERREG_EN
            DR_USER:   dr_lsb = user_sr[0];
`endif
            default:   dr_lsb = bypass_sr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else if (tck_fall) begin
            if (state_q == SHIFT_IR) begin
                tdo_q    <= ir_sr[0];
                tdo_oe_q <= 1'b1;
            end else if (state_q == SHIFT_DR) begin
                tdo_q    <= dr_lsb;
                tdo_oe_q <= 1'b1;
            end else begin
                tdo_oe_q <= 1'b0;
            end
        end
    end

    assign tdo       = tdo_q;
    assign tdo_oe    = tdo_oe_q;
    assign tap_state = state_q;
    assign ir        = ir_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Directed bench for jtag_tap_oversampled: TCK-level reference model checked
// every clk, plus literal expectations for the key scenarios.
module tb_jtag_tap_oversampled;
    import jtag_pkg::*;

    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [31:0] EXP_IDCODE  = 32'h3BA0_0477;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tck = 1'b0;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       tdo_oe;
    logic [3:0] tap_state;
    logic [3:0] ir;
    logic [7:0] user_reg;

    jtag_tap_oversampled #(
        .IDCODE      (EXP_IDCODE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_oe    (tdo_oe),
        .tap_state (tap_state),
        .ir        (ir),
        .user_reg  (user_reg)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model, advanced once per TCK edge.
    tap_state_t  nxt0 [0:15];
    tap_state_t  nxt1 [0:15];
    tap_state_t  m_state;
    logic [3:0]  m_ir, m_irsr;
    logic [31:0] m_dr;
    logic [7:0]  m_user;
    logic        m_tdo, m_oe;

    task automatic arc(input tap_state_t s, input tap_state_t n0, input tap_state_t n1);
        nxt0[s] = n0;
        nxt1[s] = n1;
    endtask

    task automatic build_graph();
        arc(TEST_LOGIC_RESET, RUN_TEST_IDLE, TEST_LOGIC_RESET);
        arc(RUN_TEST_IDLE,    RUN_TEST_IDLE, SELECT_DR);
        arc(SELECT_DR,        CAPTURE_DR,    SELECT_IR);
        arc(CAPTURE_DR,       SHIFT_DR,      EXIT1_DR);
        arc(SHIFT_DR,         SHIFT_DR,      EXIT1_DR);
        arc(EXIT1_DR,         PAUSE_DR,      UPDATE_DR);
        arc(PAUSE_DR,         PAUSE_DR,      EXIT2_DR);
        arc(EXIT2_DR,         SHIFT_DR,      UPDATE_DR);
        arc(UPDATE_DR,        RUN_TEST_IDLE, SELECT_DR);
        arc(SELECT_IR,        CAPTURE_IR,    TEST_LOGIC_RESET);
        arc(CAPTURE_IR,       SHIFT_IR,      EXIT1_IR);
        arc(SHIFT_IR,         SHIFT_IR,      EXIT1_IR);
        arc(EXIT1_IR,         PAUSE_IR,      UPDATE_IR);
        arc(PAUSE_IR,         PAUSE_IR,      EXIT2_IR);
        arc(EXIT2_IR,         SHIFT_IR,      UPDATE_IR);
        arc(UPDATE_IR,        RUN_TEST_IDLE, SELECT_DR);
    endtask

    function automatic int unsigned dr_len(input logic [3:0] i);
        if (i == 4'b0001) return 32;
`ifdef JTAG_TAP_USERREG_EN
        if (i == 4'b0010) return 8;
`endif
        return 1;
    endfunction

    task automatic model_reset();
        m_state = TEST_LOGIC_RESET;
        m_ir = 4'b0001; m_irsr = '0; m_dr = '0; m_user = '0;
        m_tdo = 1'b0; m_oe = 1'b0;
    endtask

    task automatic model_rise(input bit t_ms, input bit t_di);
        int unsigned len;
        len = dr_len(m_ir);
        if (m_state == TEST_LOGIC_RESET) m_ir = 4'b0001;
        if (m_state == CAPTURE_IR)       m_irsr = 4'b0001;
        if (m_state == SHIFT_IR)         m_irsr = {t_di, m_irsr[3:1]};
        if (m_state == UPDATE_IR)        m_ir = m_irsr;
        if (m_state == CAPTURE_DR)       m_dr = (len == 32) ? EXP_IDCODE : (len == 8) ? {24'h0, m_user} : 32'h0;
        if (m_state == SHIFT_DR) begin
            m_dr = m_dr >> 1;
            m_dr[len-1] = t_di;
        end
        if (m_state == UPDATE_DR && len == 8) m_user = m_dr[7:0];
        m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
    endtask

    task automatic model_fall();
        if (m_state == SHIFT_IR) begin
            m_tdo = m_irsr[0]; m_oe = 1'b1;
        end else if (m_state == SHIFT_DR) begin
            m_tdo = m_dr[0]; m_oe = 1'b1;
        end else begin
            m_oe = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("tap_state", 32'(tap_state), 32'(m_state));
            check("ir",        32'(ir),        32'(m_ir));
            check("tdo",       32'(tdo),       32'(m_tdo));
            check("tdo_oe",    32'(tdo_oe),    32'(m_oe));
            check("user_reg",  32'(user_reg),  32'(m_user));
        end
    end

    // One TCK period: TMS/TDI set well ahead of the rising edge, phases of 5 clk.
    task automatic tck_cycle(input bit t_ms, input bit t_di, output bit o_tdo, output bit o_oe);
        @(posedge clk); #1; tms = t_ms; tdi = t_di;
        repeat (3) @(posedge clk);
        #1; tck = 1'b1;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1; model_rise(t_ms, t_di);
        repeat (2) @(posedge clk);
        #1; tck = 1'b0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1; model_fall();
        o_tdo = tdo;
        o_oe  = tdo_oe;
        repeat (2) @(posedge clk);
    endtask

    task automatic tms_seq(input logic [7:0] bits, input int unsigned n);
        bit d, e;
        for (int unsigned i = 0; i < n; i++) tck_cycle(bits[i], 1'b0, d, e);
    endtask

    // Collects n tdo bits: the one already presented on entry to Shift plus n-1 more.
    task automatic shift(input logic [31:0] data, input int unsigned n,
                         output logic [31:0] got, output bit oe_all);
        bit d, e;
        got = '0;
        got[0] = tdo;
        oe_all = tdo_oe;
        for (int unsigned i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, data[i], d, e);
            if (i < n - 1) begin
                got[i+1] = d;
                oe_all &= e;
            end
        end
    endtask

    task automatic do_reset(input int unsigned cycles);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; model_reset();
        repeat (cycles - 1) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        bit          oe_all, d, e;

        build_graph();
        model_reset();

        do_reset(2);
        chk_en = 1'b1;
        check("rst_state",  32'(tap_state), 32'hF);
        check("rst_ir",     32'(ir),        32'h1);
        check("rst_tdo",    32'(tdo),       32'h0);
        check("rst_tdo_oe", 32'(tdo_oe),    32'h0);
        check("rst_user",   32'(user_reg),  32'h0);

        // TMS walk: into Shift-DR, then five TMS=1 edges back to reset.
        tms_seq(8'b0000_0010, 4);
        check("walk_oe_shift", 32'(tdo_oe), 32'h1);
        tck_cycle(1'b1, 1'b0, d, e);
        check("walk_oe_exit", 32'(e), 32'h0);
        check("walk_exit1", 32'(tap_state), 32'h1);
        tms_seq(8'h0F, 4);
        check("walk_tlr", 32'(tap_state), 32'hF);

        // IDCODE read.
        tms_seq(8'b0000_0010, 4);
        shift(32'h0, 32, got, oe_all);
        check("idcode_bits", got, 32'h3BA0_0477);
        check("idcode_oe", 32'(oe_all), 32'h1);
        tms_seq(8'b01, 2);

        // IR <- BYPASS.
        tms_seq(8'b0000_0011, 4);
        shift(32'hF, 4, got, oe_all);
        check("ir_capture_bits", got, 32'h1);
        tms_seq(8'b01, 2);
        check("ir_bypass", 32'(ir), 32'hF);

        // BYPASS DR: one zero, then the data delayed by one TCK.
        tms_seq(8'b001, 3);
        shift(32'h0A5, 9, got, oe_all);
        check("bypass_bits", got, 32'h14A);
        tms_seq(8'b01, 2);

        // Reset in the middle of an IDCODE shift.
        tms_seq(8'h1F, 5);
        tms_seq(8'b0000_0010, 4);
        check("tlr_restores_ir", 32'(ir), 32'h1);
        tms_seq(8'h00, 8);
        tck_cycle(1'b0, 1'b0, d, e);
        do_reset(1);
        check("midrst_state", 32'(tap_state), 32'hF);
        check("midrst_oe",    32'(tdo_oe),    32'h0);
        check("midrst_ir",    32'(ir),        32'h1);

        // USERREG write then read back.
        tms_seq(8'b0000_0110, 5);
        shift(32'h2, 4, got, oe_all);
        tms_seq(8'b01, 2);
        check("ir_user", 32'(ir), 32'h2);
        tms_seq(8'b001, 3);
        shift(32'h5A, 8, got, oe_all);
        tms_seq(8'b01, 2);
`ifdef JTAG_TAP_USERREG_EN
        check("user_reg_upd", 32'(user_reg), 32'h5A);
`else
        check("user_reg_upd", 32'(user_reg), 32'h0);
`endif
        tms_seq(8'b001, 3);
        shift(32'h0, 8, got, oe_all);
`ifdef JTAG_TAP_USERREG_EN
        check("user_reread", got, 32'h5A);
`else
        check("user_reread", got, 32'h0);
`endif
        tms_seq(8'b01, 2);

        repeat (4) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
